// File: rtl/exu_muldiv_seq_if.sv
// exu_muldiv_seq_if: execute-stage <-> RV32M sequencer handshake bundle.
// The EX stage drives the master side; the sequencer is the slave.
interface exu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            StartE;
  logic [2:0]      MulDivOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            StallMD;
  logic            DoneE;
  logic [XLEN-1:0] ResultE;

  modport master (
    output StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
    input  StallMD, DoneE, ResultE
  );

  modport slave (
    input  StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
    output StallMD, DoneE, ResultE
  );
endinterface

// File: rtl/exu_muldiv_seq.sv
// exu_muldiv_seq: radix-2 RV32M multiply/divide sequencer beside the EX ALU.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module exu_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  exu_muldiv_seq_if.slave   md
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  state_t            stateNxt;
  logic [2:0]        opR;
  logic              negR;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   bR;
  logic [2*XLEN-1:0] acc;

  logic              launch;
  logic              step;
  logic              stall;
  logic              done;

  logic              isDiv;
  logic              signA;
  logic              signB;
  logic              aNeg;
  logic              bNeg;
  logic [XLEN-1:0]   aMag;
  logic [XLEN-1:0]   bMag;
  logic              negIn;
  logic              divZero;
  logic              divOvf;
  logic              skipBusy;

  // Operand decode for the op being offered in IDLE.
  always_comb begin
    isDiv   = md.MulDivOpE[2];
    signA   = isDiv ? ~md.MulDivOpE[0]
                    : ~(md.MulDivOpE[1] & md.MulDivOpE[0]);
    signB   = isDiv ? ~md.MulDivOpE[0] : ~md.MulDivOpE[1];
    aNeg    = signA & md.SrcAE[XLEN-1];
    bNeg    = signB & md.SrcBE[XLEN-1];
    aMag    = aNeg ? -md.SrcAE : md.SrcAE;
    bMag    = bNeg ? -md.SrcBE : md.SrcBE;
    // Remainder follows the dividend; everything else is sA^sB.
    negIn   = (isDiv & md.MulDivOpE[1]) ? aNeg : (aNeg ^ bNeg);
    divZero = isDiv & (md.SrcBE == '0);
    divOvf  = isDiv & ~md.MulDivOpE[0]
            & (md.SrcAE == MinNeg) & (md.SrcBE == '1);
`ifdef MULDIV_FAST_MUL_EN
    skipBusy = divZero | divOvf | ~isDiv;
`else
    skipBusy = divZero | divOvf;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    launch   = 1'b0;
    step     = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (md.StartE & ~md.FlushE) begin
          stall    = 1'b1;
          launch   = 1'b1;
          stateNxt = skipBusy ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (md.FlushE) begin
          stateNxt = IDLE;
        end else begin
          stall = 1'b1;
          step  = 1'b1;
          if (cnt == CNT_W'(1)) stateNxt = DONE;
        end
      end
      DONE: begin
        done     = ~md.FlushE;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // acc = {hi, lo}: product hi/lo for multiply, {rem, quot} for divide.
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulNxt;
  logic              divGe;
  logic [XLEN-1:0]   divRem;
  logic [2*XLEN-1:0] divNxt;

  always_comb begin
    mulSum = {1'b0, acc[2*XLEN-1:XLEN]}
           + (acc[0] ? {1'b0, bR} : '0);
    mulNxt = {mulSum, acc[XLEN-1:1]};
    divGe  = acc[2*XLEN-1:XLEN-1] >= {1'b0, bR};
    divRem = XLEN'(acc[2*XLEN-1:XLEN-1] - {1'b0, bR});
    divNxt = {divGe ? divRem : acc[2*XLEN-2:XLEN-1],
              acc[XLEN-2:0], divGe};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      opR  <= '0;
      negR <= 1'b0;
      cnt  <= '0;
      bR   <= '0;
      acc  <= '0;
    end else if (launch) begin
      opR  <= md.MulDivOpE;
      cnt  <= CNT_W'(XLEN);
      bR   <= bMag;
      negR <= negIn;
      acc  <= {{XLEN{1'b0}}, aMag};
      // Special results are staged so the DONE mux yields them unchanged.
      if (divZero) begin
        negR <= 1'b0;
        acc  <= {md.SrcAE, {XLEN{1'b1}}};
      end else if (divOvf) begin
        negR <= 1'b0;
        acc  <= {{XLEN{1'b0}}, MinNeg};
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (~isDiv) begin
        acc <= {{XLEN{1'b0}}, aMag} * {{XLEN{1'b0}}, bMag};
      end
`endif
    end else if (step) begin
      cnt <= cnt - CNT_W'(1);
      acc <= opR[2] ? divNxt : mulNxt;
    end
  end

  logic [2*XLEN-1:0] prodS;
  logic [XLEN-1:0]   quotS;
  logic [XLEN-1:0]   remS;
  logic [XLEN-1:0]   fin;

  always_comb begin
    prodS = negR ? -acc : acc;
    quotS = negR ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remS  = negR ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    unique case (1'b1)
      opR[2] &  opR[1]:         fin = remS;
      opR[2] & ~opR[1]:         fin = quotS;
      ~opR[2] & (opR[1:0] == 2'b00): fin = prodS[XLEN-1:0];
      default:                  fin = prodS[2*XLEN-1:XLEN];
    endcase
  end

  assign md.StallMD = stall & ~RST;
  assign md.DoneE   = done & ~RST;
  assign md.ResultE = (done & ~RST) ? fin : '0;

endmodule

// File: tb/tb_exu_muldiv_seq.sv
// tb_exu_muldiv_seq: randomized RV32M checks against an arithmetic model.
// Honours MULDIV_FAST_MUL_EN for the expected multiply stall count.
module tb_exu_muldiv_seq;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vecs = 0;
  int   errs = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  exu_muldiv_seq_if #(.XLEN(32)) mdIf ();

  exu_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .md  (mdIf.slave)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] refMd(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic [31:0]     r;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0)   r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 0)   r = a;
        else if (ovf) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int refStalls(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit spec;
    spec = op[2] && (b == 0);
    spec = spec || ((op == 3'd4 || op == 3'd6)
           && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    spec = spec || (Fast && !op[2]);
    return spec ? 1 : 33;
  endfunction

  // Launches one op, scrambles the operand buses while busy, and
  // returns the result and stall count seen up to DoneE.
  task automatic doOp(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output int          stalls);
    res    = 'x;
    stalls = 0;
    @(negedge CLK);
    mdIf.StartE    = 1'b1;
    mdIf.MulDivOpE = op;
    mdIf.SrcAE     = a;
    mdIf.SrcBE     = b;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin
        mdIf.SrcAE = $urandom;
        mdIf.SrcBE = $urandom;
      end
      #1;
      if (mdIf.DoneE) begin
        res = mdIf.ResultE;
        break;
      end
      if (mdIf.StallMD) stalls++;
      @(negedge CLK);
    end
    mdIf.StartE = 1'b0;
  endtask

  task automatic test_reset;
    RST         = 1'b1;
    mdIf.StartE = 1'b1;
    mdIf.FlushE = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    vecs++;
    if (mdIf.StallMD !== 1'b0) begin
      errs++;
      $display("FAIL reset_stall got %b exp 0", mdIf.StallMD);
    end
    vecs++;
    if (mdIf.DoneE !== 1'b0) begin
      errs++;
      $display("FAIL reset_done got %b exp 0", mdIf.DoneE);
    end
    vecs++;
    if (mdIf.ResultE !== 32'h0) begin
      errs++;
      $display("FAIL reset_result got %h exp 0", mdIf.ResultE);
    end
    mdIf.StartE = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_directed;
    logic [2:0]  ops [14];
    logic [31:0] as  [14];
    logic [31:0] bs  [14];
    logic [31:0] exps[14];
    logic [31:0] res;
    int          st;
    int          expSt;
    ops = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5,
            3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    as  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            -32'sd20, -32'sd20, 32'd100, 32'd100, 32'd5, 32'd5,
            32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
    bs  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'd3, 32'd3, 32'd7, 32'd7, 32'd0,
            32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    exps = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF,
             32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd14, 32'd2,
             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0,
             32'hFFFF_FFFF, 32'd9};
    for (int i = 0; i < 14; i++) begin
      doOp(ops[i], as[i], bs[i], res, st);
      expSt = refStalls(ops[i], as[i], bs[i]);
      vecs++;
      if (res !== exps[i]) begin
        errs++;
        $display("FAIL dir%0d_result op %0d got %h exp %h",
                 i, ops[i], res, exps[i]);
      end
      vecs++;
      if (st !== expSt) begin
        errs++;
        $display("FAIL dir%0d_stalls got %0d exp %0d", i, st, expSt);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] corner [5];
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] exp;
    int          st;
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
               32'h7FFF_FFFF};
    for (int i = 0; i < 48; i++) begin
      op = 3'($urandom_range(7, 0));
      a  = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(4, 0)]
                                      : $urandom;
      b  = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(4, 0)]
                                      : $urandom;
      if ($urandom_range(3, 0) == 0) b = b >> $urandom_range(31, 0);
      doOp(op, a, b, res, st);
      exp = refMd(op, a, b);
      vecs++;
      if (res !== exp || st !== refStalls(op, a, b)) begin
        errs++;
        $display("FAIL rand%0d op %0d a %h b %h got %h/%0d exp %h/%0d",
                 i, op, a, b, res, st, exp, refStalls(op, a, b));
      end
    end
  endtask

  task automatic test_flush;
    bit          seen;
    logic [31:0] res;
    int          st;
    @(negedge CLK);
    mdIf.StartE    = 1'b1;
    mdIf.MulDivOpE = 3'd5;
    mdIf.SrcAE     = 32'd1000;
    mdIf.SrcBE     = 32'd7;
    repeat (9) @(negedge CLK);
    #1;
    vecs++;
    if (mdIf.StallMD !== 1'b1) begin
      errs++;
      $display("FAIL flush_busy_stall got %b exp 1", mdIf.StallMD);
    end
    @(negedge CLK);
    mdIf.FlushE = 1'b1;
    mdIf.StartE = 1'b0;
    #1;
    vecs++;
    if (mdIf.StallMD !== 1'b0) begin
      errs++;
      $display("FAIL flush_stall got %b exp 0", mdIf.StallMD);
    end
    @(negedge CLK);
    mdIf.FlushE = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (mdIf.DoneE !== 1'b0 || mdIf.StallMD !== 1'b0) seen = 1'b1;
      @(negedge CLK);
    end
    vecs++;
    if (seen) begin
      errs++;
      $display("FAIL flush_quiet got activity exp none");
    end
    doOp(3'd0, 32'd3, 32'd4, res, st);
    vecs++;
    if (res !== 32'd12) begin
      errs++;
      $display("FAIL flush_next_mul got %h exp 0000000c", res);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int          st;
    @(negedge CLK);
    mdIf.StartE    = 1'b1;
    mdIf.MulDivOpE = 3'd4;
    mdIf.SrcAE     = 32'd12345;
    mdIf.SrcBE     = 32'd17;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST         = 1'b0;
    mdIf.StartE = 1'b0;
    #1;
    vecs++;
    if (mdIf.StallMD !== 1'b0 || mdIf.DoneE !== 1'b0
        || mdIf.ResultE !== 32'h0) begin
      errs++;
      $display("FAIL rst_mid got stall %b done %b res %h exp 0 0 0",
               mdIf.StallMD, mdIf.DoneE, mdIf.ResultE);
    end
    doOp(3'd4, 32'd9, 32'd3, res, st);
    vecs++;
    if (res !== 32'd3 || st !== 33) begin
      errs++;
      $display("FAIL rst_mid_div got %h/%0d exp 00000003/33", res, st);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int          st;
    doOp(3'd7, 32'd100, 32'd7, res, st);
    @(negedge CLK);
    #1;
    vecs++;
    if (mdIf.DoneE !== 1'b0 || mdIf.ResultE !== 32'h0) begin
      errs++;
      $display("FAIL done_once got %b/%h exp 0/0",
               mdIf.DoneE, mdIf.ResultE);
    end
    doOp(3'd1, 32'h8000_0000, 32'h8000_0000, res, st);
    vecs++;
    if (res !== 32'h4000_0000) begin
      errs++;
      $display("FAIL b2b_mulh got %h exp 40000000", res);
    end
    doOp(3'd6, 32'h8000_0001, 32'd2, res, st);
    vecs++;
    if (res !== 32'hFFFF_FFFF) begin
      errs++;
      $display("FAIL b2b_rem got %h exp ffffffff", res);
    end
  endtask

  initial begin
    mdIf.StartE    = 1'b0;
    mdIf.MulDivOpE = 3'd0;
    mdIf.SrcAE     = '0;
    mdIf.SrcBE     = '0;
    mdIf.FlushE    = 1'b0;
    test_reset;
    test_directed;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/exu_muldiv_seq.md
Name: exu_muldiv_seq

Overview:
- Multi-cycle RV32M multiply/divide sequencer attached beside the execute-stage ALU.
- It accepts an M-extension op from the execute stage and asserts a stall to the hazard unit while iterating.
- On completion it presents a 32-bit result for one cycle, which the EX/MEM register captures in place of the ALU result.
- It owns an FSM, an iteration counter, and the operand, accumulator and sign registers.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- StartE  input  1  execute-stage instruction is an M-extension op; held high until DoneE.
- MulDivOpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  input  32  rs1 operand, already forwarded.
- SrcBE  input  32  rs2 operand, already forwarded.
- FlushE  input  1  execute-stage flush; aborts the op in flight.
- StallMD  output  1  stalls IF/ID/EX; hazard unit ORs it into its stall terms.
- DoneE  output  1  ResultE is valid this cycle.
- ResultE  output  32  final result; 0 when DoneE=0.

Behaviour:
- Reset:
  - RST=1 forces state IDLE, counter 0, all internal registers 0.
  - Outputs StallMD=0, DoneE=0, ResultE=0.
  - RST has priority over every other input, including mid-operation.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - StallMD = StartE & ~FlushE (combinational).
  - On StartE & ~FlushE, latch op, |SrcA|, |SrcB| and the result-sign flags, clear the accumulator, set counter=XLEN, go BUSY.
  - Special cases skip BUSY and go directly to DONE with the result precomputed:
    - Division by zero (op 1xx, SrcB=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give SrcA.
    - Signed overflow (DIV/REM, SrcA=0x80000000, SrcB=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- BUSY:
  - StallMD=1.
  - Each cycle performs one radix-2 step:
    - Multiply: shift-add, 64-bit product.
    - Divide: restoring shift-subtract on magnitudes.
  - The counter decrements each cycle. When it reaches 1 (last step), go DONE.
- DONE:
  - StallMD=0, DoneE=1, ResultE holds the sign-corrected result; the pipeline advances this cycle.
  - Next state is always IDLE, regardless of StartE. This prevents re-launching the same instruction.
- Latency: iterative ops take XLEN BUSY cycles + 1 DONE cycle, i.e. 33 stall cycles from the IDLE accept cycle; special cases take 1 stall cycle.
- Result selection:
  - MUL gives product[31:0].
  - MULH/MULHSU/MULHU give product[63:32] after the 64-bit two's-complement fix-up.
  - MULHSU treats only SrcA as signed.
  - DIV sign = sA^sB. REM sign = sA; the remainder takes the dividend's sign.
- FlushE:
  - In any state, FlushE forces IDLE next cycle with DoneE=0.
  - StallMD deasserts in the same cycle FlushE is seen, so the flush can proceed.
  - FlushE with StartE in IDLE does not launch.
- Operand changes on SrcAE/SrcBE while BUSY are ignored because the operands are latched.
- StartE low while BUSY (illegal) is ignored; the op completes normally.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- When defined:
  - Multiply ops (0xx) compute the full 64-bit signed/unsigned product combinationally in IDLE and go directly to DONE, for 1 stall cycle.
  - Divide ops are unchanged.
- When undefined, multiply uses the iterative BUSY path (33 stall cycles). Results are bit-identical in both builds.

Test Plan:
- MUL, SrcA=7, SrcB=0xFFFFFFFD (-3) -> StallMD high 33 cycles, then DoneE=1 with ResultE=0xFFFFFFEB. With MULDIV_FAST_MUL_EN -> StallMD high 1 cycle, same result.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> ResultE=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU -> 0xFFFFFFFF.
- DIV -20/3 -> 0xFFFFFFFA. REM -20/3 -> 0xFFFFFFFE. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with 1 stall cycle. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- DIVU launched, FlushE pulsed on BUSY cycle 10 -> StallMD=0 that cycle, state IDLE next cycle, no DoneE. A following MUL 3x4 -> ResultE=12.
- RST asserted on BUSY cycle 5 -> next cycle StallMD=0, DoneE=0, ResultE=0. A new DIV 9/3 after reset -> ResultE=3.
